// File: rtl/i2c_master_wbs_ctrl.sv
// i2c_master_wbs_ctrl: Wishbone slave front end for i2c_master with cmd/write/read FIFOs; IRQ_EN register under `I2C_WBS_IRQ_EN
module i2c_wbs_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];
    // pointers move only on a legal push/pop, judged on pre-cycle state
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    // storage needs no reset, emptiness comes from the pointers
    always_ff @(posedge clk)
        if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

module i2c_master_wbs_ctrl #(
    parameter int WB_DATA_WIDTH    = 16,
    parameter int WB_SEL_WIDTH     = WB_DATA_WIDTH / 8,
    parameter int DEFAULT_PRESCALE = 1,
    parameter int FIXED_PRESCALE   = 0,
    parameter int CMD_FIFO_DEPTH   = 16,
    parameter int WRITE_FIFO_DEPTH = 16,
    parameter int READ_FIFO_DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               wbs_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] wbs_dat_i,
    output logic [WB_DATA_WIDTH-1:0] wbs_dat_o,
    input  logic                     wbs_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  wbs_sel_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    output logic                     wbs_ack_o,
    output logic [6:0]               cmd_address,
    output logic                     cmd_start,
    output logic                     cmd_read,
    output logic                     cmd_write,
    output logic                     cmd_write_multiple,
    output logic                     cmd_stop,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [7:0]               data_in,
    output logic                     data_in_valid,
    input  logic                     data_in_ready,
    output logic                     data_in_last,
    input  logic [7:0]               data_out,
    input  logic                     data_out_valid,
    output logic                     data_out_ready,
    input  logic                     data_out_last,
    input  logic                     busy,
    input  logic                     bus_control,
    input  logic                     bus_active,
    input  logic                     missed_ack,
    output logic [15:0]              prescale,
    output logic                     irq
);
    logic acc, wr, rd, clr;
    logic [15:0] wd, rdata;
    logic [WB_DATA_WIDTH-1:0] rdata_w;
    logic [12:0] status;
    logic [12:3] irq_en;
    logic [11:0] cmd_head;
    logic [8:0] wr_head, rd_head;
    logic cmd_push, cmd_empty, cmd_full, wr_push, wr_empty, wr_full, rd_push, rd_pop, rd_empty, rd_full;
    logic ma_st, cmd_ovf, wr_ovf, rd_ovf;

    assign acc = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
    assign wr  = acc && wbs_we_i && |wbs_sel_i;
    assign rd  = acc && !wbs_we_i;
    assign clr = wr && wbs_adr_i == 3'd0;
    assign wd  = wbs_dat_i[15:0] & {{8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    assign cmd_push  = wr && wbs_adr_i == 3'd1;
    assign cmd_valid = !cmd_empty;
    assign {cmd_stop, cmd_write_multiple, cmd_write, cmd_read, cmd_start, cmd_address} = cmd_head;
    i2c_wbs_fifo #(.W(12), .DEPTH(CMD_FIFO_DEPTH)) u_cmd (
        .clk(clk), .rst(rst), .push(cmd_push), .pop(cmd_valid && cmd_ready),
        .din({wd[12:8], wd[6:0]}), .dout(cmd_head), .empty(cmd_empty), .full(cmd_full)
    );

    assign wr_push       = wr && wbs_adr_i == 3'd2;
    assign data_in_valid = !wr_empty;
    assign {data_in_last, data_in} = wr_head;
    i2c_wbs_fifo #(.W(9), .DEPTH(WRITE_FIFO_DEPTH)) u_wr (
        .clk(clk), .rst(rst), .push(wr_push), .pop(data_in_valid && data_in_ready),
        .din(wd[8:0]), .dout(wr_head), .empty(wr_empty), .full(wr_full)
    );

    assign data_out_ready = !rd_full;
    assign rd_push        = data_out_valid && data_out_ready;
    assign rd_pop         = rd && wbs_adr_i == 3'd2;
    i2c_wbs_fifo #(.W(9), .DEPTH(READ_FIFO_DEPTH)) u_rd (
        .clk(clk), .rst(rst), .push(rd_push), .pop(rd_pop),
        .din({data_out_last, data_out}), .dout(rd_head), .empty(rd_empty), .full(rd_full)
    );

    assign status = {rd_ovf, rd_full, rd_empty, wr_ovf, wr_full, wr_empty,
                     cmd_ovf, cmd_full, cmd_empty, ma_st, bus_active, bus_control, busy};

    // sticky flags: a set event in the same cycle as a clear wins
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ma_st   <= 1'b0;
            cmd_ovf <= 1'b0;
            wr_ovf  <= 1'b0;
            rd_ovf  <= 1'b0;
        end else begin
            ma_st   <= missed_ack || (ma_st && !(clr && wd[3]));
            cmd_ovf <= (cmd_push && cmd_full) || (cmd_ovf && !(clr && wd[6]));
            wr_ovf  <= (wr_push && wr_full) || (wr_ovf && !(clr && wd[9]));
            rd_ovf  <= (rd_push && rd_full) || (rd_ovf && !(clr && wd[12]));
        end

    // prescale register, frozen when the build fixes it
    always_ff @(posedge clk or posedge rst)
        if (rst) prescale <= 16'(DEFAULT_PRESCALE);
        else if (wr && wbs_adr_i == 3'd3 && FIXED_PRESCALE == 0) prescale <= wd;

`ifdef I2C_WBS_IRQ_EN
    // interrupt enable and registered level interrupt
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            irq_en <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr && wbs_adr_i == 3'd4) irq_en <= wd[12:3];
            irq <= |(status[12:3] & irq_en);
        end
`else
    assign irq_en = '0;
    assign irq    = 1'b0;
`endif

    // register read mux; DATA returns {last, valid, data} only when an entry is present
    always_comb begin
        rdata = wbs_adr_i == 3'd0 ? {3'b0, status} :
                wbs_adr_i == 3'd2 ? (rd_empty ? 16'h0 : {6'b0, rd_head[8], 1'b1, rd_head[7:0]}) :
                wbs_adr_i == 3'd3 ? prescale :
                wbs_adr_i == 3'd4 ? {3'b0, irq_en, 3'b0} : 16'h0;
        rdata_w = '0;
        rdata_w[15:0] = rdata;
    end

    // single-cycle ack with read data registered alongside it
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= acc;
            wbs_dat_o <= acc ? rdata_w : '0;
        end
endmodule

// File: tb/tb_i2c_master_wbs_ctrl.sv
// tb_i2c_master_wbs_ctrl: table vectors plus scoreboarded sequences for the 32-bit Wishbone I2C front end
module tb_i2c_master_wbs_ctrl;
    logic clk = 0, rst = 1;
    logic [2:0] adr = 0;
    logic [31:0] dat_i = 0, dat_o;
    logic we = 0, stb = 0, cyc = 0, ack;
    logic [3:0] sel = 0;
    logic [6:0] cmd_address;
    logic cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_valid, cmd_ready = 0;
    logic [7:0] data_in, data_out = 0;
    logic data_in_valid, data_in_ready = 0, data_in_last;
    logic data_out_valid = 0, data_out_ready, data_out_last = 0;
    logic busy = 0, bus_control = 0, bus_active = 0, missed_ack = 0;
    logic [15:0] prescale;
    logic irq;
    int vectors = 0, miscompares = 0;
    logic [31:0] rq[$];
    logic [11:0] cmdq[$];
    logic [8:0] wq[$];
    logic [31:0] rdq[$];
`ifdef I2C_WBS_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    typedef struct {
        logic [2:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [2:0]  st;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[22];

    always #5 clk = ~clk;

    i2c_master_wbs_ctrl #(.WB_DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat_o(dat_o),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_ack_o(ack),
        .cmd_address(cmd_address), .cmd_start(cmd_start), .cmd_read(cmd_read), .cmd_write(cmd_write),
        .cmd_write_multiple(cmd_write_multiple), .cmd_stop(cmd_stop), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready), .data_in_last(data_in_last),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready), .data_out_last(data_out_last),
        .busy(busy), .bus_control(bus_control), .bus_active(bus_active), .missed_ack(missed_ack),
        .prescale(prescale), .irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wb_cycle(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s, input logic w, output logic [31:0] q);
        logic seen = 0;
        @(negedge clk);
        adr = a; dat_i = d; sel = s; we = w; stb = 1; cyc = 1;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk); #1;
            seen = ack;
        end
        q = dat_o;
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL ack_timeout: no ack at adr %0d", a);
        end
        @(negedge clk);
        stb = 0; cyc = 0; we = 0;
    endtask

    task automatic wb_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] q;
        wb_cycle(a, d, s, 1'b1, q);
    endtask

    task automatic wb_rd(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] q;
        rq.push_back(exp);
        wb_cycle(a, 32'h0, 4'h0, 1'b0, q);
        chk(name, q, rq.pop_front());
    endtask

    // core-side monitors sample mid-low-phase, after inputs settle and before the handshake edge
    always begin
        @(negedge clk); #2;
        if (!rst && cmd_valid && cmd_ready) begin
            if (cmdq.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL cmd_unexpected: got %h expected none", {cmd_stop, cmd_write_multiple, cmd_write, cmd_read, cmd_start, cmd_address});
            end else chk("cmd_head", {20'h0, cmd_stop, cmd_write_multiple, cmd_write, cmd_read, cmd_start, cmd_address}, {20'h0, cmdq.pop_front()});
        end
        if (!rst && data_in_valid && data_in_ready) begin
            if (wq.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL wr_unexpected: got %h expected none", {data_in_last, data_in});
            end else chk("wr_head", {23'h0, data_in_last, data_in}, {23'h0, wq.pop_front()});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{3'd0, 32'h0,        4'h0, 1'b0, 3'b000, 32'h0490};
        vt[1]  = '{3'd0, 32'h0,        4'h0, 1'b0, 3'b101, 32'h0495};
        vt[2]  = '{3'd0, 32'h0,        4'h0, 1'b0, 3'b010, 32'h0492};
        vt[3]  = '{3'd3, 32'h0,        4'h0, 1'b0, 3'b000, 32'h0001};
        vt[4]  = '{3'd1, 32'h0,        4'h0, 1'b0, 3'b000, 32'h0000};
        vt[5]  = '{3'd2, 32'h0,        4'h0, 1'b0, 3'b000, 32'h0000};
        vt[6]  = '{3'd4, 32'h0,        4'h0, 1'b0, 3'b000, 32'h0000};
        vt[7]  = '{3'd5, 32'h0,        4'h0, 1'b0, 3'b000, 32'h0000};
        vt[8]  = '{3'd3, 32'hDEAD1234, 4'h1, 1'b1, 3'b000, 32'h0};
        vt[9]  = '{3'd3, 32'h0,        4'h0, 1'b0, 3'b000, 32'h0034};
        vt[10] = '{3'd3, 32'hFFFFABCD, 4'h2, 1'b1, 3'b000, 32'h0};
        vt[11] = '{3'd3, 32'h0,        4'h0, 1'b0, 3'b000, 32'hAB00};
        vt[12] = '{3'd3, 32'h00005555, 4'h0, 1'b1, 3'b000, 32'h0};
        vt[13] = '{3'd3, 32'h0,        4'h0, 1'b0, 3'b000, 32'hAB00};
        vt[14] = '{3'd3, 32'h12345678, 4'hC, 1'b1, 3'b000, 32'h0};
        vt[15] = '{3'd3, 32'h0,        4'h0, 1'b0, 3'b000, 32'h0000};
        vt[16] = '{3'd3, 32'h12345678, 4'hF, 1'b1, 3'b000, 32'h0};
        vt[17] = '{3'd3, 32'h0,        4'h0, 1'b0, 3'b000, 32'h5678};
        vt[18] = '{3'd7, 32'h0000FFFF, 4'h3, 1'b1, 3'b000, 32'h0};
        vt[19] = '{3'd7, 32'h0,        4'h0, 1'b0, 3'b000, 32'h0000};
        vt[20] = '{3'd1, 32'h0000FFFF, 4'h0, 1'b1, 3'b000, 32'h0};
        vt[21] = '{3'd0, 32'h0,        4'h0, 1'b0, 3'b000, 32'h0490};

        repeat (2) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 22; i++) begin
            {bus_active, bus_control, busy} = vt[i].st;
            if (vt[i].we) wb_wr(vt[i].adr, vt[i].dat, vt[i].sel);
            else wb_rd($sformatf("vec%0d", i), vt[i].adr, vt[i].exp);
        end
        {bus_active, bus_control, busy} = 3'b000;
        chk("prescale_port", {16'h0, prescale}, 32'h5678);

        // command FIFO overflow, then reset with entries queued
        for (int i = 0; i < 17; i++) wb_wr(3'd1, 32'h1100 + i, 4'h3);
        wb_rd("cmd_ovf_status", 3'd0, 32'h04E0);
        @(negedge clk);
        rst = 1;
        #1;
        chk("rst_cmd_valid", {31'h0, cmd_valid}, 32'h0);
        chk("rst_prescale", {16'h0, prescale}, 32'h0001);
        @(negedge clk);
        rst = 0;
        wb_rd("post_rst_status", 3'd0, 32'h0490);
        wb_rd("post_rst_prescale", 3'd3, 32'h0001);

        // single command held then drained by one ready cycle
        cmdq.push_back(12'b10101_1010000);
        wb_wr(3'd1, 32'h1550, 4'h3);
        chk("cmd_valid_after_ack", {31'h0, cmd_valid}, 32'h1);
        chk("cmd_address", {25'h0, cmd_address}, 32'h50);
        wb_rd("cmd_status", 3'd0, 32'h0480);
        @(negedge clk);
        cmd_ready = 1;
        @(posedge clk); #1;
        chk("cmd_popped", {31'h0, cmd_valid}, 32'h0);
        chk("cmdq_drained", cmdq.size(), 32'h0);
        @(negedge clk);
        cmd_ready = 0;
        wb_rd("cmd_empty_status", 3'd0, 32'h0490);

        // write FIFO fill past depth, drain in order, clear overflow
        for (int i = 0; i < 17; i++) begin
            logic [8:0] e;
            e = {i == 15, 8'(i * 17 + 3)};
            if (i < 16) wq.push_back(e);
            wb_wr(3'd2, {23'h0, e}, 4'h3);
        end
        wb_rd("wr_full_status", 3'd0, 32'h0710);
        @(negedge clk);
        data_in_ready = 1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (!data_in_valid) break;
        end
        @(negedge clk);
        data_in_ready = 0;
        chk("wq_drained", wq.size(), 32'h0);
        wb_rd("wr_ovf_held", 3'd0, 32'h0690);
        wb_wr(3'd0, 32'h0200, 4'h3);
        wb_rd("wr_ovf_cleared", 3'd0, 32'h0490);

        // read FIFO single entry, then empty read
        @(negedge clk);
        data_out = 8'hA5; data_out_last = 1; data_out_valid = 1;
        @(negedge clk);
        data_out_valid = 0;
        wb_rd("rd_a5", 3'd2, 32'h03A5);
        wb_rd("rd_empty", 3'd2, 32'h0000);
        wb_rd("rd_empty_status", 3'd0, 32'h0490);

        // read FIFO fill to full with the core stalling, then drain
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            data_out = 8'(i); data_out_last = i[0]; data_out_valid = 1;
            rdq.push_back({22'h0, i[0], 1'b1, 8'(i)});
        end
        @(negedge clk);
        data_out = 8'hEE;
        #1;
        chk("rd_full_ready", {31'h0, data_out_ready}, 32'h0);
        repeat (2) @(negedge clk);
        data_out_valid = 0;
        wb_rd("rd_full_status", 3'd0, 32'h0890);
        for (int i = 0; i < 16; i++) wb_rd($sformatf("rd_entry%0d", i), 3'd2, rdq.pop_front());
        wb_rd("rd_drained", 3'd2, 32'h0000);
        wb_rd("rd_drained_status", 3'd0, 32'h0490);

        // missed-ack interrupt path
        wb_wr(3'd4, 32'h0008, 4'h3);
        wb_rd("irq_en_rd", 3'd4, IRQ_ON ? 32'h0008 : 32'h0);
        @(negedge clk);
        missed_ack = 1;
        @(negedge clk);
        missed_ack = 0;
        #1;
        chk("irq_early", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        chk("irq_set", {31'h0, irq}, {31'h0, IRQ_ON});
        repeat (3) @(posedge clk);
        #1;
        chk("irq_held", {31'h0, irq}, {31'h0, IRQ_ON});
        wb_wr(3'd0, 32'h0008, 4'h3);
        @(posedge clk); #1;
        chk("irq_cleared", {31'h0, irq}, 32'h0);
        wb_rd("ma_cleared", 3'd0, 32'h0490);

        // set beats clear when missed_ack coincides with the clearing write
        @(negedge clk);
        missed_ack = 1;
        wb_wr(3'd0, 32'h0008, 4'h3);
        missed_ack = 0;
        wb_rd("set_wins", 3'd0, 32'h0498);
        wb_wr(3'd0, 32'h0008, 4'h3);
        wb_rd("ma_final_clear", 3'd0, 32'h0490);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
